// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron learning loop.
package perceptron_pkg;

  localparam int WEIGHT_W = 32;

  localparam logic signed [WEIGHT_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [WEIGHT_W-1:0] SAT_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    UPDATE,
    DONE
  } state_e;

  // err = target - prediction, which can only take these three values.
  typedef enum logic [1:0] {
    ERR_ZERO,
    ERR_POS,
    ERR_NEG
  } err_e;

endpackage

// File: rtl/sat_add32.sv
// Combinational signed add that clamps to the 32-bit range instead of wrapping.
module sat_add32
  import perceptron_pkg::*;
(
  input  logic signed [WEIGHT_W-1:0] a,
  input  logic signed [WEIGHT_W-1:0] b,
  output logic signed [WEIGHT_W-1:0] y
);

  logic signed [WEIGHT_W:0] sum_ext;

  always_comb begin
    sum_ext = {a[WEIGHT_W-1], a} + {b[WEIGHT_W-1], b};
    // Overflow shows up as the two top bits disagreeing; bit 32 gives the direction.
    if (sum_ext[WEIGHT_W] != sum_ext[WEIGHT_W-1]) begin
      y = sum_ext[WEIGHT_W] ? SAT_MIN : SAT_MAX;
    end else begin
      y = sum_ext[WEIGHT_W-1:0];
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Single-layer perceptron trainer: thresholds the supplied sum, then walks the
// weight bank one entry per cycle applying the perceptron rule with saturation.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int                          N         = 8,
  parameter int                          LR_SHIFT  = 8,
  parameter logic signed [WEIGHT_W-1:0]  THRESHOLD = '0,
  localparam int                         IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic [N-1:0]                   x,
  input  logic                           target,
  input  logic signed [WEIGHT_W-1:0]     sum,
  input  logic                           w_load,
  input  logic [IDX_W-1:0]               w_load_idx,
  input  logic [WEIGHT_W-1:0]            w_load_data,
  output logic [WEIGHT_W*N-1:0]          w,
  output logic                           busy,
  output logic                           update_done,
  output logic                           mistake,
  output logic [15:0]                    mistake_count
);

  localparam logic signed [WEIGHT_W-1:0] STEP     = 1 << LR_SHIFT;
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]             N_EXT    = (IDX_W + 1)'(N);

  state_e                       state;
  state_e                       state_next;
  logic [N-1:0]                 x_q;
  logic                         target_q;
  logic signed [WEIGHT_W-1:0]   sum_q;
  err_e                         err_q;
  err_e                         err_eval;
  logic [IDX_W-1:0]             idx;
  logic signed [WEIGHT_W-1:0]   weights [N];
  logic signed [WEIGHT_W-1:0]   cur_w;
  logic signed [WEIGHT_W-1:0]   step_signed;
  logic signed [WEIGHT_W-1:0]   upd_w;
  logic                         accept;
  logic                         load_en;
  logic                         upd_en;

  assign accept      = (state == IDLE) && sample_valid;
  assign load_en     = (state == IDLE) && w_load && ({1'b0, w_load_idx} < N_EXT);
  assign upd_en      = (state == UPDATE) && x_q[idx];
  assign cur_w       = weights[idx];
  assign step_signed = (err_q == ERR_NEG) ? -STEP : STEP;

  sat_add32 u_sat_add (
    .a (cur_w),
    .b (step_signed),
    .y (upd_w)
  );

  always_comb begin
    err_eval = ERR_ZERO;
    if ((sum_q >= THRESHOLD) != target_q) begin
      err_eval = target_q ? ERR_POS : ERR_NEG;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    sample_ready = 1'b0;
    busy         = 1'b1;
    update_done  = 1'b0;
    mistake      = 1'b0;
    case (state)
      IDLE: begin
        sample_ready = 1'b1;
        busy         = 1'b0;
        if (accept) state_next = EVAL;
      end
      EVAL:   state_next = (err_eval == ERR_ZERO) ? DONE : UPDATE;
      UPDATE: if (idx == LAST_IDX) state_next = DONE;
      DONE: begin
        update_done = 1'b1;
        mistake     = (err_q != ERR_ZERO);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      target_q      <= 1'b0;
      sum_q         <= '0;
      err_q         <= ERR_ZERO;
      idx           <= '0;
      mistake_count <= '0;
    end else begin
      if (accept) begin
        x_q      <= x;
        target_q <= target;
        sum_q    <= sum;
      end
      case (state)
        EVAL: begin
          err_q <= err_eval;
          idx   <= '0;
        end
        UPDATE: idx <= idx + 1'b1;
        DONE: begin
          if (err_q != ERR_ZERO && mistake_count != 16'hFFFF) begin
            mistake_count <= mistake_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the weight bank is reset explicitly; a reset mid-update must discard partial results.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        weights[i] <= '0;
      end else if (load_en && w_load_idx == IDX_W'(i)) begin
        weights[i] <= w_load_data;
      end else if (upd_en && idx == IDX_W'(i)) begin
        weights[i] <= upd_w;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_w_out
    assign w[WEIGHT_W*g +: WEIGHT_W] = weights[g];
  end

  a_done_returns_idle: assert property (@(posedge clk) disable iff (rst)
    update_done |=> sample_ready);
  a_mistake_with_done: assert property (@(posedge clk) disable iff (rst)
    mistake |-> update_done);

endmodule
